// File: rtl/smm_pkg.sv
// Shared types and constants for the sequential matrix multiplier.
package smm_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    OUT,
    ACKW,
    DONE
  } state_t;

endpackage

// File: rtl/smm_mac.sv
// Multiply-accumulate datapath; SMM_SATURATE_EN selects clamping instead of wrap.
module smm_mac
  import smm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] acc_sum
);

  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] sum;

`ifdef SMM_SATURATE_EN
  function automatic logic [DATA_W-1:0] clamp(input logic signed [2*DATA_W-1:0] v);
    logic signed [2*DATA_W-1:0] hi;
    logic signed [2*DATA_W-1:0] lo;
    hi = {{DATA_W{SAT_MAX[DATA_W-1]}}, SAT_MAX};
    lo = {{DATA_W{SAT_MIN[DATA_W-1]}}, SAT_MIN};
    if (v > hi)      return SAT_MAX;
    else if (v < lo) return SAT_MIN;
    else             return v[DATA_W-1:0];
  endfunction

  logic signed [2*DATA_W-1:0] a_w, b_w, prod_w, sum_w;
  logic        [DATA_W-1:0]   prod_c;

  always_comb begin
    a_w    = {{DATA_W{a[DATA_W-1]}}, a};
    b_w    = {{DATA_W{b[DATA_W-1]}}, b};
    prod_w = a_w * b_w;
    prod_c = clamp(prod_w);
    sum_w  = {{DATA_W{acc_q[DATA_W-1]}}, acc_q} + {{DATA_W{prod_c[DATA_W-1]}}, prod_c};
    sum    = clamp(sum_w);
  end
`else
  logic signed [DATA_W-1:0] a_s, b_s, prod;

  always_comb begin
    a_s  = a;
    b_s  = b;
    prod = a_s * b_s;
    sum  = acc_q + prod;
  end
`endif

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  // Includes the current product so the final term is visible in the last MAC cycle.
  assign acc_sum = sum;

endmodule

// File: rtl/seq_matrix_multiplier.sv
// Sequential MxM matrix multiplier: FSM, index counters and four-phase result handshake.
// Build option: SMM_SATURATE_EN (saturating accumulation inside smm_mac).
module seq_matrix_multiplier
  import smm_pkg::*;
#(
  parameter int M     = 4,
  parameter int M_LEN = (M > 1) ? $clog2(M) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              z_ack,
  output logic [M_LEN-1:0]  a_i,
  output logic [M_LEN-1:0]  a_j,
  output logic [M_LEN-1:0]  b_i,
  output logic [M_LEN-1:0]  b_j,
  output logic [DATA_W-1:0] z_out,
  output logic [M_LEN-1:0]  z_i,
  output logic [M_LEN-1:0]  z_j,
  output logic              z_stb,
  output logic              done
);

  localparam logic [M_LEN-1:0] LAST = M_LEN'(M - 1);
  localparam logic [M_LEN-1:0] ONE  = M_LEN'(1);

  state_t             state_q, state_d;
  logic [M_LEN-1:0]   row_q, row_d, col_q, col_d, k_q, k_d;
  logic [M_LEN-1:0]   zi_q, zi_d, zj_q, zj_d;
  logic [DATA_W-1:0]  zout_q, zout_d;
  logic               stb_q, stb_d, done_q, done_d;
  logic               mac_clr, mac_en;
  logic [DATA_W-1:0]  acc_sum;

  smm_mac u_mac (
    .clk     (clk),
    .rst     (rst),
    .clr     (mac_clr),
    .en      (mac_en),
    .a       (a_in),
    .b       (b_in),
    .acc_sum (acc_sum)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    zi_d    = zi_q;
    zj_d    = zj_q;
    zout_d  = zout_q;
    stb_d   = stb_q;
    done_d  = done_q;
    mac_clr = 1'b1;
    mac_en  = 1'b0;
    case (state_q)
      IDLE: begin
        row_d = '0;
        col_d = '0;
        k_d   = '0;
        if (start) state_d = MAC;
      end
      MAC: begin
        mac_clr = 1'b0;
        mac_en  = 1'b1;
        if (k_q == LAST) begin
          zout_d  = acc_sum;
          zi_d    = row_q;
          zj_d    = col_q;
          stb_d   = 1'b1;
          state_d = OUT;
        end else begin
          k_d = k_q + ONE;
        end
      end
      OUT: begin
        if (z_ack) begin
          stb_d   = 1'b0;
          state_d = ACKW;
        end
      end
      // Four-phase: the ack must drop before the next element starts.
      ACKW: begin
        if (!z_ack) begin
          if (row_q == LAST && col_q == LAST) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            k_d     = '0;
            state_d = MAC;
            if (col_q == LAST) begin
              col_d = '0;
              row_d = row_q + ONE;
            end else begin
              col_d = col_q + ONE;
            end
          end
        end
      end
      DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      zi_q    <= '0;
      zj_q    <= '0;
      zout_q  <= '0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      zi_q    <= zi_d;
      zj_q    <= zj_d;
      zout_q  <= zout_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
    end
  end

  assign a_i   = row_q;
  assign a_j   = k_q;
  assign b_i   = k_q;
  assign b_j   = col_q;
  assign z_out = zout_q;
  assign z_i   = zi_q;
  assign z_j   = zj_q;
  assign z_stb = stb_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_matrix_multiplier.sv
// Self-checking bench: matrix-product reference model plus per-cycle result monitor.
module tb_seq_matrix_multiplier;

  localparam int M  = 4;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          z_ack = 1'b0;
  logic [31:0]   a_in, b_in, z_out;
  logic [ML-1:0] a_i, a_j, b_i, b_j, z_i, z_j;
  logic          z_stb, done;

  logic [31:0]   A [M][M];
  logic [31:0]   B [M][M];

  typedef struct {
    int          i;
    int          j;
    logic [31:0] v;
  } res_t;

  res_t        expq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          got = 0;
  logic        stb_seen = 1'b0;
  logic [31:0] held_v;

  seq_matrix_multiplier #(.M(M), .M_LEN(ML)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .z_ack (z_ack),
    .a_i   (a_i),
    .a_j   (a_j),
    .b_i   (b_i),
    .b_j   (b_j),
    .z_out (z_out),
    .z_i   (z_i),
    .z_j   (z_j),
    .z_stb (z_stb),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign a_in = A[a_i][a_j];
  assign b_in = B[b_i][b_j];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint clampl(input longint v);
    if (v > 64'sd2147483647)       return 64'sd2147483647;
    else if (v < -64'sd2147483648) return -64'sd2147483648;
    else                           return v;
  endfunction

  // Reference element of Z = A*B
  function automatic logic [31:0] model_elem(input int i, input int j);
`ifdef SMM_SATURATE_EN
    longint s = 0;
    for (int k = 0; k < M; k++) begin
      int ai = A[i][k];
      int bi = B[k][j];
      s = clampl(s + clampl(longint'(ai) * longint'(bi)));
    end
    return s[31:0];
`else
    logic [31:0] s = 32'd0;
    for (int k = 0; k < M; k++) s = s + A[i][k] * B[k][j];
    return s;
`endif
  endfunction

  task automatic fill_expected();
    res_t e;
    expq.delete();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        e.i = i; e.j = j; e.v = model_elem(i, j);
        expq.push_back(e);
      end
  endtask

  // Result monitor: each new strobe must match the next row-major expectation.
  always @(negedge clk) begin : monitor
    res_t e;
    if (!rst) begin
      stb_seen = 1'b0;
    end else if (z_stb && !stb_seen) begin
      stb_seen = 1'b1;
      held_v   = z_out;
      got++;
      if (expq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL extra_result: got z(%0d,%0d)=%h expected no result", z_i, z_j, z_out);
      end else begin
        e = expq.pop_front();
        chk("z_out", z_out, e.v);
        chk("z_i", 32'(z_i), 32'(e.i));
        chk("z_j", 32'(z_j), 32'(e.j));
      end
    end else if (z_stb) begin
      chk("z_out_hold", z_out, held_v);
    end else begin
      stb_seen = 1'b0;
    end
  end

  task automatic wait_stb(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (z_stb) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL stb_timeout: z_stb=0 expected 1");
    end
  endtask

  task automatic run_mult(input int dmax, input int hmax, input bit timing);
    bit ok;
    int prev, d, h;
    fill_expected();
    got = 0;
    @(negedge clk);
    start = 1'b1;
    prev  = cyc;
    for (int e = 0; e < M * M; e++) begin
      wait_stb(ok);
      if (!ok) begin start = 1'b0; return; end
      if (timing) chk("elem_cycles", 32'(cyc - prev), (e == 0) ? 32'(M + 1) : 32'(M + 2));
      prev = cyc;
      chk("done_early", 32'(done), 32'd0);
      d = $urandom_range(dmax, 0);
      repeat (d) begin
        @(negedge clk);
        chk("stb_wait_ack", 32'(z_stb), 32'd1);
      end
      z_ack = 1'b1;
      h = $urandom_range(hmax, 1);
      repeat (h) @(negedge clk);
      chk("stb_drop", 32'(z_stb), 32'd0);
      z_ack = 1'b0;
    end
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk("done_rise", 32'(ok), 32'd1);
    chk("result_count", 32'(got), 32'(M * M));
    chk("results_left", 32'(expq.size()), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("done_hold", 32'(done), 32'd1);
    end
    start = 1'b0;
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_z_stb"}, 32'(z_stb), 32'd0);
    chk({tag, "_done"},  32'(done),  32'd0);
    chk({tag, "_z_out"}, z_out,      32'd0);
    chk({tag, "_idx"},   32'({a_i, a_j, b_i, b_j, z_i, z_j}), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    rst = 1'b0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin A[i][j] = 32'd0; B[i][j] = 32'd0; end
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    // Identity times index matrix
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        A[i][j] = (i == j) ? 32'd1 : 32'd0;
        B[i][j] = 32'(4 * i + j);
      end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) chk("model_ident", model_elem(i, j), 32'(4 * i + j));
    run_mult(0, 1, 1'b1);

    // All twos, strict minimum timing
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin A[i][j] = 32'd2; B[i][j] = 32'd2; end
    chk("model_twos", model_elem(2, 3), 32'd16);
    run_mult(0, 1, 1'b1);

    // Product overflow
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin A[i][j] = 32'd0; B[i][j] = 32'd0; end
    A[0][0] = 32'h0001_0000;
    B[0][0] = 32'h0001_0000;
`ifdef SMM_SATURATE_EN
    chk("model_ovf", model_elem(0, 0), 32'h7FFF_FFFF);
`else
    chk("model_ovf", model_elem(0, 0), 32'h0000_0000);
`endif
    run_mult(0, 1, 1'b0);

    // Slow and sticky acknowledges with random data
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin A[i][j] = $urandom; B[i][j] = $urandom; end
    run_mult(5, 3, 1'b0);

    // Reset in the middle of element (1,2)
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin A[i][j] = $urandom_range(1000, 0); B[i][j] = $urandom; end
    fill_expected();
    got = 0;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e < 6; e++) begin
      wait_stb(ok);
      z_ack = 1'b1;
      @(negedge clk);
      z_ack = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("mid_row", 32'(a_i), 32'd1);
    chk("mid_col", 32'(b_j), 32'd2);
    rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    expq.delete();
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_mult(2, 2, 1'b0);

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < M; j++) begin
          A[i][j] = (r[0]) ? $urandom : 32'($urandom_range(20, 0)) - 32'd10;
          B[i][j] = (r[0]) ? $urandom : 32'($urandom_range(20, 0)) - 32'd10;
        end
      run_mult(3, 2, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
